// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode/execute boundary.
// ALU opcodes, forwarding selects and the registered control bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND       = 4'd0,
    ALU_OR        = 4'd1,
    ALU_ADD       = 4'd2,
    ALU_XOR       = 4'd3,
    ALU_SUB       = 4'd6,
    ALU_SLT       = 4'd7,
    ALU_ADDU_QB   = 4'd8,
    ALU_ADDU_S_QB = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // ALU control is kept as raw bits: every 4-bit code passes through
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle with forwarding sources and E-stage results.
// master drives decode/hazard/forward inputs; slave is the stage.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [WIDTH-1:0] RD1D;
  logic [WIDTH-1:0] RD2D;
  logic [WIDTH-1:0] SignImmD;
  logic [RADDR-1:0] RsD;
  logic [RADDR-1:0] RtD;
  logic [RADDR-1:0] RdD;
  logic [3:0]       ALUControlD;
  logic             ALUSrcD;
  logic             RegDstD;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             MemWriteD;
  logic             StallE;
  logic             FlushE;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] ResultW;
  logic [RADDR-1:0] WriteRegM;
  logic [RADDR-1:0] WriteRegW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [3:0]       ALUControlE;
  logic [WIDTH-1:0] WriteDataE;
  logic [RADDR-1:0] WriteRegE;
  logic [RADDR-1:0] RsE;
  logic [RADDR-1:0] RtE;
  logic             RegWriteE;
  logic             MemtoRegE;
  logic             MemWriteE;

  modport master (
    output RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output ALUControlD, ALUSrcD, RegDstD,
    output RegWriteD, MemtoRegD, MemWriteD,
    output StallE, FlushE,
    output ALUOutM, ResultW, WriteRegM, WriteRegW,
    output RegWriteM, RegWriteW,
    input  SrcAE, SrcBE, ALUControlE, WriteDataE,
    input  WriteRegE, RsE, RtE,
    input  RegWriteE, MemtoRegE, MemWriteE
  );

  modport slave (
    input  RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input  ALUControlD, ALUSrcD, RegDstD,
    input  RegWriteD, MemtoRegD, MemWriteD,
    input  StallE, FlushE,
    input  ALUOutM, ResultW, WriteRegM, WriteRegW,
    input  RegWriteM, RegWriteW,
    output SrcAE, SrcBE, ALUControlE, WriteDataE,
    output WriteRegE, RsE, RtE,
    output RegWriteE, MemtoRegE, MemWriteE
  );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Operand bypass for one E-stage source register.
// Memory stage wins over writeback; register 0 never forwards.
module forward_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs,
  input  logic [WIDTH-1:0] rd,
  input  logic             reg_write_m,
  input  logic [RADDR-1:0] write_reg_m,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic             reg_write_w,
  input  logic [RADDR-1:0] write_reg_w,
  input  logic [WIDTH-1:0] result_w,
  output logic [WIDTH-1:0] data
);
  fwd_sel_e sel;
  logic     hit_m;
  logic     hit_w;

  assign hit_m = reg_write_m && (write_reg_m == rs) && (rs != '0);
  assign hit_w = reg_write_w && (write_reg_w == rs) && (rs != '0);

  always_comb begin
    sel = FWD_REG;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end

  always_comb begin
    data = rd;
    unique case (sel)
      FWD_MEM: data = alu_out_m;
      FWD_WB:  data = result_w;
      default: data = rd;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and execute muxes.
// Flush beats stall; reset clears all state asynchronously.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
);
  logic [WIDTH-1:0] rd1_q;
  logic [WIDTH-1:0] rd2_q;
  logic [WIDTH-1:0] imm_q;
  logic [RADDR-1:0] rs_q;
  logic [RADDR-1:0] rt_q;
  logic [RADDR-1:0] rd_q;
  id_ex_ctrl_t      ctrl_q;
  id_ex_ctrl_t      ctrl_d;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  assign ctrl_d = '{
    alu_ctrl:   bus.ALUControlD,
    alu_src:    bus.ALUSrcD,
    reg_dst:    bus.RegDstD,
    reg_write:  bus.RegWriteD,
    mem_to_reg: bus.MemtoRegD,
    mem_write:  bus.MemWriteD
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else if (bus.FlushE) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else if (!bus.StallE) begin
      rd1_q  <= bus.RD1D;
      rd2_q  <= bus.RD2D;
      imm_q  <= bus.SignImmD;
      rs_q   <= bus.RsD;
      rt_q   <= bus.RtD;
      rd_q   <= bus.RdD;
      ctrl_q <= ctrl_d;
    end
  end

  forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_a (
    .rs          (rs_q),
    .rd          (rd1_q),
    .reg_write_m (bus.RegWriteM),
    .write_reg_m (bus.WriteRegM),
    .alu_out_m   (bus.ALUOutM),
    .reg_write_w (bus.RegWriteW),
    .write_reg_w (bus.WriteRegW),
    .result_w    (bus.ResultW),
    .data        (fwd_a)
  );

  forward_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_b (
    .rs          (rt_q),
    .rd          (rd2_q),
    .reg_write_m (bus.RegWriteM),
    .write_reg_m (bus.WriteRegM),
    .alu_out_m   (bus.ALUOutM),
    .reg_write_w (bus.RegWriteW),
    .write_reg_w (bus.WriteRegW),
    .result_w    (bus.ResultW),
    .data        (fwd_b)
  );

  assign bus.SrcAE       = fwd_a;
  assign bus.WriteDataE  = fwd_b;
  assign bus.SrcBE       = ctrl_q.alu_src ? imm_q : fwd_b;
  assign bus.ALUControlE = ctrl_q.alu_ctrl;
  assign bus.WriteRegE   = ctrl_q.reg_dst ? rd_q : rt_q;
  assign bus.RsE         = rs_q;
  assign bus.RtE         = rt_q;
  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.MemtoRegE   = ctrl_q.mem_to_reg;
  assign bus.MemWriteE   = ctrl_q.mem_write;
endmodule
